// File: rtl/hsk_skid_pipe.sv
// Valid/ready pipeline of DEPTH cascaded skid-buffer stages; every output comes straight from a register.
// Optional occupancy counter port is enabled by defining HSK_SKID_PIPE_OCC_EN.
module hsk_skid_pipe #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    input  logic [WORD_WIDTH-1:0] up_data,
    output logic                  up_ready,
    output logic                  down_valid,
    output logic [WORD_WIDTH-1:0] down_data,
    input  logic                  down_ready
`ifdef HSK_SKID_PIPE_OCC_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

    // Handshake: a transfer happens on an interface when valid and ready are both
    // high at a rising clk edge; a producer holds its data until that edge.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    stage_state_e          r_state     [DEPTH];
    stage_state_e          w_state_nxt [DEPTH];
    logic [WORD_WIDTH-1:0] r_main      [DEPTH];
    logic [WORD_WIDTH-1:0] r_skid      [DEPTH];
    logic [WORD_WIDTH-1:0] w_main_nxt  [DEPTH];
    logic [WORD_WIDTH-1:0] w_skid_nxt  [DEPTH];
    logic [WORD_WIDTH-1:0] w_in_data   [DEPTH];
    logic [DEPTH-1:0]      w_in_valid;
    logic [DEPTH-1:0]      w_in_ready;
    logic [DEPTH-1:0]      w_out_valid;
    logic [DEPTH-1:0]      w_out_ready;
    logic [DEPTH-1:0]      w_in_xfer;
    logic [DEPTH-1:0]      w_out_xfer;
    logic                  r_up_en;

    // Stage interconnect: every ready/valid here is a decode of a state register.
    always_comb begin
        w_in_valid  = '0;
        w_in_ready  = '0;
        w_out_valid = '0;
        w_out_ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_in_data[k]   = '0;
            w_in_ready[k]  = (r_state[k] != ST_FULL);
            w_out_valid[k] = (r_state[k] != ST_EMPTY);
        end
        w_in_valid[0] = up_valid & r_up_en;
        w_in_data[0]  = up_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_in_valid[k] = w_out_valid[k-1];
            w_in_data[k]  = r_main[k-1];
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_out_ready[k] = w_in_ready[k+1];
        end
        w_out_ready[DEPTH-1] = down_ready;
        w_in_xfer  = w_in_valid & w_in_ready;
        w_out_xfer = w_out_valid & w_out_ready;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_state_nxt[k] = r_state[k];
            w_main_nxt[k]  = r_main[k];
            w_skid_nxt[k]  = r_skid[k];
            case (r_state[k])
                ST_EMPTY: begin
                    if (w_in_xfer[k]) begin
                        w_state_nxt[k] = ST_BUSY;
                        w_main_nxt[k]  = w_in_data[k];
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer[k] && w_out_xfer[k]) begin
                        w_main_nxt[k] = w_in_data[k];
                    end else if (w_in_xfer[k]) begin
                        w_state_nxt[k] = ST_FULL;
                        w_skid_nxt[k]  = w_in_data[k];
                    end else if (w_out_xfer[k]) begin
                        w_state_nxt[k] = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_out_xfer[k]) begin
                        w_state_nxt[k] = ST_BUSY;
                        w_main_nxt[k]  = r_skid[k];
                    end
                end
                default: w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_en <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_state[k] <= ST_EMPTY;
                r_main[k]  <= '0;
                r_skid[k]  <= '0;
            end
        end else begin
            r_up_en <= 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_main[k]  <= w_main_nxt[k];
                r_skid[k]  <= w_skid_nxt[k];
            end
        end
    end

    // r_up_en keeps up_ready low until the first edge after reset releases.
    assign up_ready   = r_up_en & w_in_ready[0];
    assign down_valid = w_out_valid[DEPTH-1];
    assign down_data  = r_main[DEPTH-1];

`ifdef HSK_SKID_PIPE_OCC_EN
    logic [$clog2(2*DEPTH+1)-1:0] r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (w_in_xfer[0] && !w_out_xfer[DEPTH-1]) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_in_xfer[0] && w_out_xfer[DEPTH-1]) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_hsk_skid_pipe.sv
// Scoreboard bench for hsk_skid_pipe: a DEPTH=2 instance for flow, backpressure, reset and
// random traffic, plus a DEPTH=1 instance for capacity and ready-path independence.
`timescale 1ns/1ps
module tb_hsk_skid_pipe;
    localparam int W = 8;
    localparam int D = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         up_valid = 1'b0;
    logic [W-1:0] up_data  = '0;
    logic         up_ready;
    logic         down_valid;
    logic [W-1:0] down_data;
    logic         down_ready = 1'b0;

    logic         d1_up_valid = 1'b0;
    logic [W-1:0] d1_up_data  = '0;
    logic         d1_up_ready;
    logic         d1_down_valid;
    logic [W-1:0] d1_down_data;
    logic         d1_down_ready = 1'b0;

`ifdef HSK_SKID_PIPE_OCC_EN
    logic [$clog2(2*D+1)-1:0] occupancy;
    logic [1:0]               d1_occupancy;
`endif

    hsk_skid_pipe #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_ready (down_ready)
`ifdef HSK_SKID_PIPE_OCC_EN
        ,
        .occupancy  (occupancy)
`endif
    );

    hsk_skid_pipe #(.WORD_WIDTH(W), .DEPTH(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (d1_up_valid),
        .up_data    (d1_up_data),
        .up_ready   (d1_up_ready),
        .down_valid (d1_down_valid),
        .down_data  (d1_down_data),
        .down_ready (d1_down_ready)
`ifdef HSK_SKID_PIPE_OCC_EN
        ,
        .occupancy  (d1_occupancy)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         last_acc = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    bit           rst_evt = 1'b0;
    int           occ_m = 0;

    // Upstream accepts are sampled mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        last_acc = up_valid && up_ready;
        if (up_valid && up_ready) exp_q.push_back(up_data);
    end

    always @(posedge rst) rst_evt = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            rst_evt    = 1'b0;
            occ_m      = 0;
        end else begin
            if (prev_stall && !rst_evt) begin
                check("stall_valid", 32'(down_valid), 32'd1);
                check("stall_data", 32'(down_data), 32'(prev_data));
            end
            rst_evt = 1'b0;
            if (down_valid && down_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: got 0x%0h want no word at %0t", down_data, $time);
                end else begin
                    check("out_data", 32'(down_data), 32'(exp_q.pop_front()));
                end
            end
`ifdef HSK_SKID_PIPE_OCC_EN
            check("occupancy", 32'(occupancy), 32'(occ_m));
            occ_m += int'(up_valid && up_ready) - int'(down_valid && down_ready);
`endif
            prev_stall = down_valid && !down_ready;
            prev_data  = down_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        int n;
        int cyc;
        int d1_idx;
        logic         ur;
        logic         v;
        logic [W-1:0] d1_q[$];

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_up_ready", 32'(up_ready), 32'd0);
        check("rst_down_valid", 32'(down_valid), 32'd0);
        check("rst_down_data", 32'(down_data), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_up_ready", 32'(up_ready), 32'd1);

        // Flow: 0x11,0x22,0x33 back-to-back with down_ready high.
        down_ready = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'h11;
        tick();
        check("t1_lat_e0", 32'(down_valid), 32'd0);
        check("t1_up_ready0", 32'(up_ready), 32'd1);
        up_data = 8'h22;
        tick();
        check("t1_lat_e1", 32'(down_valid), 32'd1);
        check("t1_data0", 32'(down_data), 32'h11);
        check("t1_up_ready1", 32'(up_ready), 32'd1);
        up_data = 8'h33;
        tick();
        check("t1_data1", 32'(down_data), 32'h22);
        up_valid = 1'b0;
        tick();
        check("t1_data2", 32'(down_data), 32'h33);
        check("t1_valid2", 32'(down_valid), 32'd1);
        tick();
        check("t1_empty", 32'(down_valid), 32'd0);

        // Backpressure: 0xA0..0xA5 offered with down_ready low.
        down_ready = 1'b0;
        idx = 0;
        up_valid = 1'b1;
        up_data  = 8'hA0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) begin
                idx++;
                up_data = 8'(8'hA0 + idx);
            end
            check("t2_up_ready", 32'(up_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        check("t2_accepted", 32'(idx), 32'd4);
        check("t2_head", 32'(down_data), 32'hA0);
        down_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t2_no_gap", 32'(down_valid), 32'd1);
            tick();
            if (up_valid && last_acc) begin
                idx++;
                if (idx < 6) up_data = 8'(8'hA0 + idx);
                else up_valid = 1'b0;
            end
        end
        check("t2_all_in", 32'(idx), 32'd6);
        check("t2_drained", 32'(down_valid), 32'd0);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset with 3 words held.
        down_ready = 1'b0;
        up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_data = 8'(8'h71 + i);
            tick();
        end
        up_valid = 1'b0;
        check("t3_held", 32'(down_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t3_rst_dv", 32'(down_valid), 32'd0);
        check("t3_rst_dd", 32'(down_data), 32'd0);
        check("t3_rst_ur", 32'(up_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t3_ur_release", 32'(up_ready), 32'd0);
        tick();
        check("t3_ur_next_edge", 32'(up_ready), 32'd1);
        down_ready = 1'b1;
        up_valid = 1'b1;
        up_data  = 8'h5A;
        tick();
        up_valid = 1'b0;
        check("t3_lat_e0", 32'(down_valid), 32'd0);
        tick();
        check("t3_lat_e1", 32'(down_valid), 32'd1);
        check("t3_5a", 32'(down_data), 32'h5A);
        tick();
        check("t3_empty", 32'(down_valid), 32'd0);

        // Random traffic, 1000 words.
        n = 0;
        cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            tick();
            cyc++;
            if (up_valid && last_acc) n++;
            if (!up_valid || last_acc) begin
                if (n < 1000 && $urandom_range(0, 1) == 1) begin
                    up_valid = 1'b1;
                    up_data  = 8'($urandom_range(0, 255));
                end else begin
                    up_valid = 1'b0;
                end
            end
            down_ready = ($urandom_range(0, 1) == 1);
        end
        up_valid = 1'b0;
        check("t4_count", 32'(n), 32'd1000);
        down_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || down_valid) && cyc < 50) begin
            tick();
            cyc++;
        end
        check("t4_drain", 32'(exp_q.size()), 32'd0);

        // DEPTH=1: capacity 2, then alternating down_ready toggled mid-cycle.
        d1_down_ready = 1'b0;
        d1_up_valid = 1'b1;
        d1_idx = 0;
        d1_up_data = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            if (d1_up_ready) begin
                d1_q.push_back(d1_up_data);
                d1_idx++;
            end
            tick();
            d1_up_data = 8'(8'hC0 + d1_idx);
        end
        check("d1_capacity", 32'(d1_idx), 32'd2);
        check("d1_full_ready", 32'(d1_up_ready), 32'd0);
        check("d1_head", 32'(d1_down_data), 32'hC0);
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0);
            d1_down_ready = v;
            ur = d1_up_ready;
            #1 d1_down_ready = ~v;
            #1 check("d1_no_comb_path", 32'(d1_up_ready), 32'(ur));
            #1 d1_down_ready = v;
            if (d1_up_valid && d1_up_ready) d1_q.push_back(d1_up_data);
            if (v && d1_down_valid) begin
                if (d1_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d1_pop_empty: got 0x%0h want no word", d1_down_data);
                end else begin
                    check("d1_out", 32'(d1_down_data), 32'(d1_q.pop_front()));
                end
            end
            if (d1_up_valid && d1_up_ready) begin
                d1_idx++;
                tick();
                d1_up_data = 8'(8'hC0 + d1_idx);
            end else begin
                tick();
            end
        end
        d1_up_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
